// File: rtl/redmule_mx_input_stage_if.sv
// Valid/ready stream bundle (hwpe_stream style) used on every port of the MX input stage.
// The source drives valid/data/strb; the sink drives ready.
interface redmule_mx_input_stage_if #(
  parameter int unsigned DATAW = 512
) ();
  logic               valid;
  logic               ready;
  logic [DATAW-1:0]   data;
  logic [DATAW/8-1:0] strb;

  modport master (output valid, output data, output strb, input ready);
  modport slave  (input valid, input data, input strb, output ready);
endinterface

// File: rtl/redmule_mx_input_stage.sv
// MX input stage: pairs FP8 (E4M3) value beats with E8M0 shared exponents and
// decodes them to FP16 lanes through a two-stage pipeline; transparent bypass when MX is off.
module redmule_mx_input_stage #(
  parameter int unsigned DATAW_ALIGN = 512,
  parameter int unsigned BITW        = 16,
  parameter int unsigned Width       = 32,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            clear_i,
  input  logic                            mx_enable_i,
  redmule_mx_input_stage_if.slave         x_stream_i,
  redmule_mx_input_stage_if.slave         mx_exp_stream_i,
  redmule_mx_input_stage_if.master        x_muxed_o,
  output logic                            busy_o,
  output logic [31:0]                     beat_cnt_o
);

  localparam int unsigned VALW  = 8 * Width;
  localparam int unsigned OUTW  = BITW * Width;
  localparam int unsigned PTRW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNTW  = $clog2(FIFO_DEPTH + 1);

  // FP8 E4M3 lane with shared E8M0 exponent -> FP16, truncating toward zero
  function automatic logic [15:0] f_decode(input logic [7:0] v, input logic [7:0] x);
    logic              s;
    logic [3:0]        e;
    logic [2:0]        m;
    logic [2:0]        frac;
    logic signed [9:0] ex;
    logic signed [9:0] b;
    logic [9:0]        sh;
    logic [10:0]       sig;
    logic [15:0]       res;
    s    = v[7];
    e    = v[6:3];
    m    = v[2:0];
    frac = m;
    ex   = $signed({6'b0, e}) - 10'sd7;
    if (e == 4'd0) begin
      casez (m)
        3'b1??:  begin ex = -10'sd7; frac = {m[1:0], 1'b0}; end
        3'b01?:  begin ex = -10'sd8; frac = {m[0], 2'b0};   end
        default: begin ex = -10'sd9; frac = 3'b0;           end
      endcase
    end
    b   = ex + $signed({2'b0, x}) - 10'sd112;
    sh  = 10'(10'sd1 - b);
    sig = {1'b1, frac, 7'b0};
    res = '0;
    if (x == 8'hFF)                          res = 16'h7E00;
    else if (e == 4'd15 && m == 3'd7)        res = {s, 15'h7E00};
    else if (e == 4'd0 && m == 3'd0)         res = {s, 15'h0};
    else if (b >= 10'sd31)                   res = {s, 15'h7C00};
    else if (b >= 10'sd1)                    res = {s, b[4:0], frac, 7'b0};
    else if (sh >= 10'd11)                   res = {s, 15'h0};
    else begin
      sig = sig >> sh;
      res = {s, 15'(sig)};
    end
    return res;
  endfunction

  function automatic logic [PTRW-1:0] f_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(FIFO_DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  logic [VALW-1:0] r_vmem [FIFO_DEPTH];
  logic [7:0]      r_emem [FIFO_DEPTH];
  logic [PTRW-1:0] r_vwr, r_vrd, r_ewr, r_erd;
  logic [CNTW-1:0] r_vcnt, r_ecnt;
  logic            r_s1_valid, r_s2_valid;
  logic [VALW-1:0] r_s1_lanes;
  logic [7:0]      r_s1_exp;
  logic [OUTW-1:0] r_s2_data;
  logic [31:0]     r_beat_cnt;

  logic            w_vfull, w_vempty, w_efull, w_eempty;
  logic            w_vpush, w_epush, w_pop;
  logic            w_s2_drain, w_s2_free, w_s1_move, w_s1_free;
  logic [OUTW-1:0] w_dec;

  assign w_vfull    = (r_vcnt == CNTW'(FIFO_DEPTH));
  assign w_efull    = (r_ecnt == CNTW'(FIFO_DEPTH));
  assign w_vempty   = (r_vcnt == '0);
  assign w_eempty   = (r_ecnt == '0);
  assign w_vpush    = mx_enable_i & x_stream_i.valid & ~w_vfull;
  assign w_epush    = mx_enable_i & mx_exp_stream_i.valid & ~w_efull;
  assign w_s2_drain = mx_enable_i & r_s2_valid & x_muxed_o.ready;
  assign w_s2_free  = ~r_s2_valid | w_s2_drain;
  assign w_s1_move  = mx_enable_i & r_s1_valid & w_s2_free;
  assign w_s1_free  = ~r_s1_valid | w_s1_move;
  assign w_pop      = mx_enable_i & ~w_vempty & ~w_eempty & w_s1_free;

  // FIFO storage carries no reset; only pointers and counts define occupancy
  always_ff @(posedge clk_i) begin
    if (w_vpush && !clear_i) r_vmem[r_vwr] <= x_stream_i.data[VALW-1:0];
    if (w_epush && !clear_i) r_emem[r_ewr] <= mx_exp_stream_i.data[7:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vwr <= '0; r_vrd <= '0; r_vcnt <= '0;
      r_ewr <= '0; r_erd <= '0; r_ecnt <= '0;
    end else if (clear_i) begin
      r_vwr <= '0; r_vrd <= '0; r_vcnt <= '0;
      r_ewr <= '0; r_erd <= '0; r_ecnt <= '0;
    end else begin
      if (w_vpush) r_vwr <= f_inc(r_vwr);
      if (w_epush) r_ewr <= f_inc(r_ewr);
      if (w_pop) begin
        r_vrd <= f_inc(r_vrd);
        r_erd <= f_inc(r_erd);
      end
      case ({w_vpush, w_pop})
        2'b10:   r_vcnt <= r_vcnt + CNTW'(1);
        2'b01:   r_vcnt <= r_vcnt - CNTW'(1);
        default: r_vcnt <= r_vcnt;
      endcase
      case ({w_epush, w_pop})
        2'b10:   r_ecnt <= r_ecnt + CNTW'(1);
        2'b01:   r_ecnt <= r_ecnt - CNTW'(1);
        default: r_ecnt <= r_ecnt;
      endcase
    end
  end

  // S1 holds the raw paired beat, S2 the decoded beat
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid <= 1'b0; r_s1_lanes <= '0; r_s1_exp <= '0;
      r_s2_valid <= 1'b0; r_s2_data  <= '0; r_beat_cnt <= '0;
    end else if (clear_i) begin
      r_s1_valid <= 1'b0; r_s1_lanes <= '0; r_s1_exp <= '0;
      r_s2_valid <= 1'b0; r_s2_data  <= '0; r_beat_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_s1_valid <= 1'b1;
        r_s1_lanes <= r_vmem[r_vrd];
        r_s1_exp   <= r_emem[r_erd];
      end else if (w_s1_move) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s1_move) begin
        r_s2_valid <= 1'b1;
        r_s2_data  <= w_dec;
      end else if (w_s2_drain) begin
        r_s2_valid <= 1'b0;
      end
      if (w_s2_drain) r_beat_cnt <= r_beat_cnt + 32'd1;
    end
  end

  always_comb begin
    w_dec = '0;
    for (int i = 0; i < int'(Width); i++) begin
      w_dec[i*BITW +: BITW] = BITW'(f_decode(r_s1_lanes[8*i +: 8], r_s1_exp));
    end
  end

  // Bypass forwards the raw stream combinationally and leaves stored state alone
  always_comb begin
    x_muxed_o.valid = r_s2_valid;
    x_muxed_o.data  = DATAW_ALIGN'(r_s2_data);
    x_muxed_o.strb  = '1;
    x_stream_i.ready = ~w_vfull;
    if (!mx_enable_i) begin
      x_muxed_o.valid  = x_stream_i.valid;
      x_muxed_o.data   = x_stream_i.data;
      x_muxed_o.strb   = x_stream_i.strb;
      x_stream_i.ready = x_muxed_o.ready;
    end
  end

  assign mx_exp_stream_i.ready = mx_enable_i & ~w_efull;
  assign busy_o     = ~w_vempty | ~w_eempty | r_s1_valid | r_s2_valid;
  assign beat_cnt_o = r_beat_cnt;

endmodule

// File: tb/tb_redmule_mx_input_stage.sv
// Bench for redmule_mx_input_stage: directed vector table, multi-cycle corner sequences
// and a randomized run scored against a value-level FP8/E8M0 -> FP16 model.
module tb_redmule_mx_input_stage;
  localparam int unsigned DW = 512;
  localparam int unsigned W  = 32;

  logic        clk, rst_n, clear, mx_en, busy;
  logic [31:0] beat_cnt;

  redmule_mx_input_stage_if #(.DATAW(DW)) x_if ();
  redmule_mx_input_stage_if #(.DATAW(DW)) e_if ();
  redmule_mx_input_stage_if #(.DATAW(DW)) o_if ();

  redmule_mx_input_stage #(.DATAW_ALIGN(DW), .BITW(16), .Width(W), .FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .mx_enable_i(mx_en),
    .x_stream_i(x_if), .mx_exp_stream_i(e_if), .x_muxed_o(o_if),
    .busy_o(busy), .beat_cnt_o(beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before the end of the test");
    $fatal(1, "watchdog");
  end

  typedef struct packed { logic [7:0] v; logic [7:0] x; logic [15:0] y; } vec_t;
  vec_t tbl [13];

  int checks = 0, errors = 0;
  int n_xacc = 0, n_out = 0, exp_cnt = 0, ntick = 0, first_out = -1, last_out = -1;
  logic [255:0] vq [$];
  logic [7:0]   eq [$];
  bit           hold = 1'b0;
  logic [DW-1:0] hold_data;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_i(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Value-level model: lane = sig * 2^k, then re-encoded as FP16 with truncation
  function automatic logic [15:0] m_lane(input logic [7:0] v, input logic [7:0] x);
    int e, m, sig, k, l, n, sh, q;
    logic [15:0] sb;
    e  = int'(v[6:3]);
    m  = int'(v[2:0]);
    sb = {v[7], 15'h0};
    if (x == 8'hFF) return 16'h7E00;
    if (e == 15 && m == 7) return sb | 16'h7E00;
    if (e == 0) begin sig = m; k = -9; end
    else begin sig = 8 + m; k = e - 10; end
    if (sig == 0) return sb;
    k = k + int'(x) - 127;
    l = 0;
    for (int i = 0; i < 4; i++) if (((sig >> i) & 1) != 0) l = i;
    n = l + k;
    if (n + 15 >= 31) return sb | 16'h7C00;
    if (n + 15 >= 1) return sb | 16'((n + 15) << 10) | 16'((sig << (10 - l)) & 'h3FF);
    sh = k + 24;
    if (sh >= 0) q = sig << sh;
    else if (sh <= -8) q = 0;
    else q = sig >> (-sh);
    return sb | 16'(q);
  endfunction

  function automatic logic [DW-1:0] m_beat(input logic [255:0] l, input logic [7:0] x);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < int'(W); i++) r[16*i +: 16] = m_lane(l[8*i +: 8], x);
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_bus();
    logic [DW-1:0] r;
    for (int i = 0; i < int'(DW / 32); i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [7:0] rnd_x();
    int c;
    c = int'($urandom_range(0, 7));
    if (c == 0) return 8'hFF;
    if (c < 3) return 8'($urandom);
    return 8'($urandom_range(95, 160));
  endfunction

  task automatic drive(input bit xv, input logic [255:0] lanes, input bit ev,
                       input logic [7:0] xe, input bit ordy);
    logic [DW-1:0] t;
    t = rnd_bus();
    x_if.valid = xv;
    x_if.data  = {t[DW-1:256], lanes};
    x_if.strb  = t[63:0];
    t = rnd_bus();
    e_if.valid = ev;
    e_if.data  = {t[DW-1:8], xe};
    e_if.strb  = t[63:0];
    o_if.ready = ordy;
  endtask

  // One clock: score handshakes at the falling edge, then advance past the rising edge
  task automatic tick();
    logic [255:0] v;
    logic [7:0]   xx;
    @(negedge clk);
    if (clear) begin
      vq.delete(); eq.delete(); exp_cnt = 0; hold = 1'b0;
    end else if (mx_en) begin
      if (hold) begin
        check_i("hold_valid", longint'(o_if.valid), 1);
        check("hold_data", o_if.data, hold_data);
      end
      if (x_if.valid && x_if.ready) begin vq.push_back(x_if.data[255:0]); n_xacc++; end
      if (e_if.valid && e_if.ready) eq.push_back(e_if.data[7:0]);
      if (o_if.valid && o_if.ready) begin
        n_out++; exp_cnt++;
        if (first_out < 0) first_out = ntick;
        last_out = ntick;
        check_i("pair_avail", longint'(vq.size() != 0 && eq.size() != 0), 1);
        if (vq.size() != 0 && eq.size() != 0) begin
          v  = vq.pop_front();
          xx = eq.pop_front();
          check("decode", o_if.data, m_beat(v, xx));
        end
      end
      hold      = o_if.valid && !o_if.ready;
      hold_data = o_if.data;
    end
    @(posedge clk);
    #1;
    ntick++;
  endtask

  task automatic run_vec(input logic [7:0] v, input logic [7:0] x, input logic [15:0] y,
                         input int cnt);
    logic [255:0] lanes;
    logic [DW-1:0] yy;
    lanes = {W{v}};
    yy    = DW'({W{y}});
    drive(1'b1, lanes, 1'b1, x, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 8'h0, 1'b1);
    check_i("lat_edge0", longint'(o_if.valid), 0);
    tick();
    check_i("lat_edge1", longint'(o_if.valid), 0);
    tick();
    check_i("lat_edge2", longint'(o_if.valid), 1);
    check("table_data", o_if.data, yy);
    tick();
    check_i("beat_cnt", longint'(beat_cnt), cnt);
    check_i("post_valid", longint'(o_if.valid), 0);
  endtask

  initial begin
    logic [255:0] lanes;
    int a0, e0, o0, c0;

    tbl[0]  = '{8'h38, 8'd127, 16'h3C00};
    tbl[1]  = '{8'h38, 8'd128, 16'h4000};
    tbl[2]  = '{8'h01, 8'd127, 16'h1800};
    tbl[3]  = '{8'h7F, 8'd127, 16'h7E00};
    tbl[4]  = '{8'hFF, 8'd127, 16'hFE00};
    tbl[5]  = '{8'h80, 8'd127, 16'h8000};
    tbl[6]  = '{8'h7E, 8'd143, 16'h7C00};
    tbl[7]  = '{8'h38, 8'd107, 16'h0010};
    tbl[8]  = '{8'h38, 8'hFF,  16'h7E00};
    tbl[9]  = '{8'hB8, 8'hFF,  16'h7E00};
    tbl[10] = '{8'h08, 8'd127, 16'h2400};
    tbl[11] = '{8'h07, 8'd127, 16'h2300};
    tbl[12] = '{8'hC8, 8'd127, 16'hC400};

    rst_n = 1'b0; clear = 1'b0; mx_en = 1'b1;
    drive(1'b0, '0, 1'b0, 8'h0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    check_i("rst_busy", longint'(busy), 0);
    check_i("rst_valid", longint'(o_if.valid), 0);
    check("rst_data", o_if.data, '0);
    check_i("rst_cnt", longint'(beat_cnt), 0);
    check_i("rst_xrdy", longint'(x_if.ready), 1);
    check_i("rst_erdy", longint'(e_if.ready), 1);

    for (int i = 0; i < 13; i++) run_vec(tbl[i].v, tbl[i].x, tbl[i].y, i + 1);

    // Mixed specials in one beat
    lanes = rnd_bus()[255:0];
    lanes[7:0] = 8'h01; lanes[15:8] = 8'h7F; lanes[23:16] = 8'hFF; lanes[31:24] = 8'h80;
    drive(1'b1, lanes, 1'b1, 8'd127, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 8'h0, 1'b1);
    tick(); tick();
    check_i("mix_valid", longint'(o_if.valid), 1);
    check_i("mix_l0", longint'(o_if.data[15:0]), 'h1800);
    check_i("mix_l1", longint'(o_if.data[31:16]), 'h7E00);
    check_i("mix_l2", longint'(o_if.data[47:32]), 'hFE00);
    check_i("mix_l3", longint'(o_if.data[63:48]), 'h8000);
    tick();

    // Exponent withheld for 5 cycles
    drive(1'b1, rnd_bus()[255:0], 1'b0, 8'h0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 8'h0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check_i("wait_valid", longint'(o_if.valid), 0);
      tick();
    end
    drive(1'b0, '0, 1'b1, 8'd120, 1'b1);
    check_i("wait_valid", longint'(o_if.valid), 0);
    tick();
    drive(1'b0, '0, 1'b0, 8'h0, 1'b1);
    check_i("wexp_edge0", longint'(o_if.valid), 0);
    tick();
    check_i("wexp_edge1", longint'(o_if.valid), 0);
    tick();
    check_i("wexp_edge2", longint'(o_if.valid), 1);
    tick();

    // Output stalled for 10 cycles under continuous input
    a0 = n_xacc; o0 = n_out;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, rnd_bus()[255:0], 1'b1, rnd_x(), 1'b0);
      tick();
    end
    check_i("bp_accepted", longint'(n_xacc - a0), 4);
    check_i("bp_xrdy", longint'(x_if.ready), 0);
    check_i("bp_erdy", longint'(e_if.ready), 0);
    check_i("bp_busy", longint'(busy), 1);
    drive(1'b0, '0, 1'b0, 8'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check_i("bp_burst", longint'(o_if.valid), 1);
      tick();
    end
    check_i("bp_end", longint'(o_if.valid), 0);
    check_i("bp_outs", longint'(n_out - o0), 4);

    // Eight back-to-back pairs must emerge as an unbroken run
    a0 = n_xacc; o0 = n_out; first_out = -1; last_out = -1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, rnd_bus()[255:0], 1'b1, rnd_x(), 1'b1);
      tick();
    end
    drive(1'b0, '0, 1'b0, 8'h0, 1'b1);
    repeat (4) tick();
    check_i("tp_accepted", longint'(n_xacc - a0), 8);
    check_i("tp_outs", longint'(n_out - o0), 8);
    check_i("tp_span", longint'(last_out - first_out + 1), 8);
    check_i("tp_cnt", longint'(beat_cnt), exp_cnt);

    // Bypass mode
    check_i("byp_idle", longint'(busy), 0);
    c0 = exp_cnt;
    mx_en = 1'b0;
    for (int k = 0; k < 40; k++) begin
      drive(1'($urandom), rnd_bus()[255:0], 1'($urandom), rnd_x(), 1'($urandom));
      #1;
      check_i("byp_valid", longint'(o_if.valid), longint'(x_if.valid));
      check("byp_data", o_if.data, x_if.data);
      check_i("byp_strb", longint'(o_if.strb), longint'(x_if.strb));
      check_i("byp_xrdy", longint'(x_if.ready), longint'(o_if.ready));
      check_i("byp_erdy", longint'(e_if.ready), 0);
      tick();
    end
    check_i("byp_cnt", longint'(beat_cnt), c0);
    drive(1'b0, '0, 1'b0, 8'h0, 1'b1);
    mx_en = 1'b1;
    #1;
    check_i("byp_busy", longint'(busy), 0);

    // Clear with three beats in flight
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, rnd_bus()[255:0], 1'b1, rnd_x(), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 8'h0, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_i("clr_busy", longint'(busy), 0);
    check_i("clr_valid", longint'(o_if.valid), 0);
    check_i("clr_cnt", longint'(beat_cnt), 0);
    check("clr_data", o_if.data, '0);
    run_vec(8'h38, 8'd127, 16'h3C00, 1);

    // Randomized MX traffic with random backpressure
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, rnd_bus()[255:0], $urandom_range(0, 3) != 0,
            rnd_x(), $urandom_range(0, 9) < 7);
      tick();
    end
    for (int k = 0; k < 12 && vq.size() != eq.size(); k++) begin
      drive(vq.size() < eq.size(), rnd_bus()[255:0], eq.size() < vq.size(), rnd_x(), 1'b1);
      tick();
    end
    drive(1'b0, '0, 1'b0, 8'h0, 1'b1);
    for (int k = 0; k < 30 && busy; k++) tick();
    check_i("drain_busy", longint'(busy), 0);
    check_i("drain_vq", longint'(vq.size()), 0);
    check_i("drain_eq", longint'(eq.size()), 0);
    check_i("drain_cnt", longint'(beat_cnt), exp_cnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
